// File: rtl/ast_mux.sv
// Avalon-ST packet mux: round-robin per packet, 1-cycle registered latency, 1 IDLE arbitration cycle between packets.
// Backpressure: the output beat freezes while !ast_ready_i, and the granted sink's ready follows output-register space.
module ast_mux #(
  parameter int DATA_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 8,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int RX_DIR        = 4,
  parameter int DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
  input  logic                                   clk_i,
  input  logic                                   arst_i,
  input  logic [RX_DIR-1:0][DATA_WIDTH-1:0]      ast_data_i,
  input  logic [RX_DIR-1:0]                      ast_startofpacket_i,
  input  logic [RX_DIR-1:0]                      ast_endofpacket_i,
  input  logic [RX_DIR-1:0]                      ast_valid_i,
  input  logic [RX_DIR-1:0][EMPTY_WIDTH-1:0]     ast_empty_i,
  input  logic [RX_DIR-1:0][CHANNEL_WIDTH-1:0]   ast_channel_i,
  output logic [RX_DIR-1:0]                      ast_ready_o,
  output logic [DATA_WIDTH-1:0]                  ast_data_o,
  output logic                                   ast_startofpacket_o,
  output logic                                   ast_endofpacket_o,
  output logic                                   ast_valid_o,
  output logic [EMPTY_WIDTH-1:0]                 ast_empty_o,
  output logic [CHANNEL_WIDTH-1:0]               ast_channel_o,
  output logic [DIR_SEL_WIDTH-1:0]               dir_o,
  input  logic                                   ast_ready_i
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                   state_q, state_d;
  logic [DIR_SEL_WIDTH-1:0] grant_q, grant_d;
  logic [DIR_SEL_WIDTH-1:0] last_q, last_d;

  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     sop_q, sop_d;
  logic                     eop_q, eop_d;
  logic                     vld_q, vld_d;
  logic [EMPTY_WIDTH-1:0]   empty_q, empty_d;
  logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
  logic [DIR_SEL_WIDTH-1:0] dir_q, dir_d;

  logic                     arb_found;
  logic [DIR_SEL_WIDTH-1:0] arb_idx;
  logic                     org_free;
  logic                     accept;

  // Rotating scan starting just after the previous winner.
  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_idx   = last_q;
    idx       = 0;
    for (int i = 1; i <= RX_DIR; i++) begin
      idx = (int'(last_q) + i) % RX_DIR;
      if (!arb_found && ast_valid_i[idx]) begin
        arb_found = 1'b1;
        arb_idx   = DIR_SEL_WIDTH'(idx);
      end
    end
  end

  assign org_free = !vld_q || ast_ready_i;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    ast_ready_o = '0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          last_d  = arb_idx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        ast_ready_o[grant_q] = org_free;
        accept               = org_free && ast_valid_i[grant_q];
        if (accept && ast_endofpacket_i[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    vld_d   = vld_q;
    empty_d = empty_q;
    chan_d  = chan_q;
    dir_d   = dir_q;
    if (accept) begin
      data_d  = ast_data_i[grant_q];
      sop_d   = ast_startofpacket_i[grant_q];
      eop_d   = ast_endofpacket_i[grant_q];
      empty_d = ast_empty_i[grant_q];
      chan_d  = ast_channel_i[grant_q];
      dir_d   = grant_q;
      vld_d   = 1'b1;
    end else if (ast_ready_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= DIR_SEL_WIDTH'(RX_DIR - 1);
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      vld_q   <= 1'b0;
      empty_q <= '0;
      chan_q  <= '0;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      vld_q   <= vld_d;
      empty_q <= empty_d;
      chan_q  <= chan_d;
      dir_q   <= dir_d;
    end
  end

  assign ast_data_o          = data_q;
  assign ast_startofpacket_o = sop_q;
  assign ast_endofpacket_o   = eop_q;
  assign ast_valid_o         = vld_q;
  assign ast_empty_o         = empty_q;
  assign ast_channel_o       = chan_q;
  assign dir_o               = dir_q;

endmodule

// File: tb/tb_ast_mux.sv
// Bench for ast_mux: per-sink expected-packet queues filled at generation, drained by dir_o on the output.
module tb_ast_mux;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int EW = 3;
  localparam int N  = 4;
  localparam int SW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [CW-1:0] chan;
  } beat_t;

  logic                  clk_i = 1'b0;
  logic                  arst_i;
  logic [N-1:0][DW-1:0]  ast_data_i;
  logic [N-1:0]          ast_startofpacket_i;
  logic [N-1:0]          ast_endofpacket_i;
  logic [N-1:0]          ast_valid_i;
  logic [N-1:0][EW-1:0]  ast_empty_i;
  logic [N-1:0][CW-1:0]  ast_channel_i;
  logic [N-1:0]          ast_ready_o;
  logic [DW-1:0]         ast_data_o;
  logic                  ast_startofpacket_o;
  logic                  ast_endofpacket_o;
  logic                  ast_valid_o;
  logic [EW-1:0]         ast_empty_o;
  logic [CW-1:0]         ast_channel_o;
  logic [SW-1:0]         dir_o;
  logic                  ast_ready_i;

  ast_mux #(
    .DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .EMPTY_WIDTH(EW), .RX_DIR(N), .DIR_SEL_WIDTH(SW)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .ast_data_i(ast_data_i), .ast_startofpacket_i(ast_startofpacket_i),
    .ast_endofpacket_i(ast_endofpacket_i), .ast_valid_i(ast_valid_i),
    .ast_empty_i(ast_empty_i), .ast_channel_i(ast_channel_i), .ast_ready_o(ast_ready_o),
    .ast_data_o(ast_data_o), .ast_startofpacket_o(ast_startofpacket_o),
    .ast_endofpacket_o(ast_endofpacket_o), .ast_valid_o(ast_valid_o),
    .ast_empty_o(ast_empty_o), .ast_channel_o(ast_channel_o), .dir_o(dir_o),
    .ast_ready_i(ast_ready_i)
  );

  always #5 clk_i = ~clk_i;

  beat_t stim_q[N][$];
  beat_t exp_q[N][$];
  int    grant_log[$];
  int    checks = 0;
  int    failures = 0;
  int    out_beats = 0;
  bit    rdy_rand, gap_en;
  bit    m_lock;
  int    m_grant, m_last;
  bit    prev_hold;
  beat_t prev_out;
  logic [SW-1:0] prev_dir;
  logic [SW-1:0] out_dir;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t out_beat();
    return {ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o};
  endfunction

  function automatic int pending();
    int n = int'(ast_valid_o);
    for (int s = 0; s < N; s++) n += stim_q[s].size() + exp_q[s].size();
    return n;
  endfunction

  task automatic push_beat(input int s, input beat_t b);
    stim_q[s].push_back(b);
    exp_q[s].push_back(b);
  endtask

  task automatic gen_pkt(input int s, input int len);
    beat_t b;
    logic [CW-1:0] ch;
    ch = CW'($urandom_range(0, 255));
    for (int i = 0; i < len; i++) begin
      b.data  = {$urandom(), $urandom()};
      b.sop   = (i == 0);
      b.eop   = (i == len - 1);
      b.empty = b.eop ? EW'($urandom_range(0, 7)) : '0;
      b.chan  = ch;
      push_beat(s, b);
    end
  endtask

  task automatic reset_model();
    for (int s = 0; s < N; s++) begin
      stim_q[s].delete();
      exp_q[s].delete();
    end
    ast_valid_i = '0;
    m_lock      = 1'b0;
    m_grant     = 0;
    m_last      = N - 1;
    prev_hold   = 1'b0;
  endtask

  // One clock: drive at negedge, settle, then check and predict the coming posedge.
  task automatic step();
    logic [N-1:0] exp_rdy;
    beat_t b;
    bit lock_n;
    int s2;
    @(negedge clk_i);
    ast_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int s = 0; s < N; s++) begin
      if (stim_q[s].size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
        b = stim_q[s][0];
        ast_valid_i[s]         = 1'b1;
        ast_data_i[s]          = b.data;
        ast_startofpacket_i[s] = b.sop;
        ast_endofpacket_i[s]   = b.eop;
        ast_empty_i[s]         = b.empty;
        ast_channel_i[s]       = b.chan;
      end else begin
        ast_valid_i[s] = 1'b0;
      end
    end
    #1;
    if (prev_hold) chk("hold", {dir_o, out_beat()}, {prev_dir, prev_out});

    exp_rdy = '0;
    lock_n  = m_lock;
    if (!m_lock) begin
      if (|ast_valid_i) begin
        for (int i = 1; i <= N; i++) begin
          s2 = (m_last + i) % N;
          if (ast_valid_i[s2]) begin
            m_grant = s2;
            break;
          end
        end
        m_last = m_grant;
        lock_n = 1'b1;
      end
    end else if (!ast_valid_o || ast_ready_i) begin
      exp_rdy[m_grant] = 1'b1;
    end
    chk("ready", ast_ready_o, exp_rdy);

    if (ast_valid_o && ast_ready_i) begin
      out_beats++;
      chk("beat_expected", exp_q[dir_o].size() > 0, 1);
      if (exp_q[dir_o].size() > 0) begin
        b = exp_q[dir_o].pop_front();
        chk("beat", out_beat(), b);
      end
      if (!ast_startofpacket_o) chk("contig_dir", dir_o, out_dir);
      out_dir = dir_o;
    end

    for (int s = 0; s < N; s++) begin
      if (ast_valid_i[s] && ast_ready_o[s] && stim_q[s].size() > 0) begin
        b = stim_q[s].pop_front();
        if (b.sop) grant_log.push_back(s);
        if (b.eop) lock_n = 1'b0;
      end
    end
    m_lock    = lock_n;
    prev_hold = ast_valid_o && !ast_ready_i;
    prev_out  = out_beat();
    prev_dir  = dir_o;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (pending() > 0 && n < maxc) begin
      step();
      n++;
    end
    chk("drain_left", pending(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    arst_i = 1'b1;
    reset_model();
    @(negedge clk_i);
    #2 arst_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    arst_i = 1'b1;
    ast_ready_i = 1'b0;
    ast_data_i = '0;
    ast_startofpacket_i = '0;
    ast_endofpacket_i = '0;
    ast_empty_i = '0;
    ast_channel_i = '0;
    rdy_rand = 1'b0;
    gap_en = 1'b0;
    out_dir = '0;
    reset_model();
    #12;
    chk("rst_out", {ast_valid_o, ast_startofpacket_o, ast_endofpacket_o, ast_data_o,
                    ast_empty_o, ast_channel_o, dir_o}, '0);
    chk("rst_rdy", ast_ready_o, '0);
    @(negedge clk_i);
    #2 arst_i = 1'b0;

    // Single-beat packet on sink 2: ready at the second cycle, output on the third.
    push_beat(2, {64'hA5, 1'b1, 1'b1, 3'd3, 8'd7});
    step();
    chk("t1_rdy_c1", ast_ready_o[2], 0);
    step();
    chk("t1_rdy_c2", ast_ready_o[2], 1);
    step();
    chk("t1_vld_c3", ast_valid_o, 1);
    chk("t1_data", ast_data_o, 64'hA5);
    chk("t1_empty", ast_empty_o, 3);
    chk("t1_chan", ast_channel_o, 7);
    chk("t1_dir", dir_o, 2);
    drain(50);

    // Three competing sinks after reset: served 0,1,3.
    do_reset();
    grant_log.delete();
    gen_pkt(0, 3);
    gen_pkt(1, 3);
    gen_pkt(3, 3);
    drain(100);
    chk("t2_count", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("t2_g0", grant_log[0], 0);
      chk("t2_g1", grant_log[1], 1);
      chk("t2_g2", grant_log[2], 3);
    end

    // Five beats under random output backpressure.
    rdy_rand = 1'b1;
    n = out_beats;
    gen_pkt(1, 5);
    drain(200);
    chk("t3_beats", out_beats - n, 5);
    rdy_rand = 1'b0;

    // Sink 0 streams; sink 3 must slot in after sink 0's current packet.
    grant_log.delete();
    for (int p = 0; p < 4; p++) gen_pkt(0, 2);
    step();
    gen_pkt(3, 2);
    drain(100);
    chk("t4_count", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      chk("t4_g0", grant_log[0], 0);
      chk("t4_g1", grant_log[1], 3);
      chk("t4_g2", grant_log[2], 0);
    end

    // Reset mid-packet between clock edges.
    gen_pkt(2, 6);
    n = 0;
    while (!ast_valid_o && n < 20) begin
      step();
      n++;
    end
    chk("t5_started", ast_valid_o, 1);
    #2 arst_i = 1'b1;
    #1;
    chk("t5_rst_out", {ast_valid_o, ast_startofpacket_o, ast_endofpacket_o, ast_data_o,
                       ast_empty_o, ast_channel_o, dir_o}, '0);
    chk("t5_rst_rdy", ast_ready_o, '0);
    reset_model();
    repeat (2) @(negedge clk_i);
    #2 arst_i = 1'b0;
    grant_log.delete();
    gen_pkt(3, 2);
    gen_pkt(0, 2);
    drain(100);
    chk("t5_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t5_g0", grant_log[0], 0);
      chk("t5_g1", grant_log[1], 3);
    end

    // Long random mix with gaps and backpressure.
    rdy_rand = 1'b1;
    gap_en   = 1'b1;
    for (int p = 0; p < 40; p++) gen_pkt(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 6)));
    drain(5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
